// File: rtl/rs_station_param_pkg.sv
// Shared constants, default widths and entry record for the parametrised reservation station.
package rs_station_param_pkg;

  localparam int RS_DEPTH_DEF  = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int ROB_W_DEF     = 4;
  localparam int OP_W_DEF      = 6;
  localparam int CDB_PORTS_DEF = 2;

  localparam logic [ROB_W_DEF-1:0] ZERO_ROB = '0;
  localparam logic [OP_W_DEF-1:0]  NOP_OP   = '0;

  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [ROB_W_DEF-1:0]  qj;
    logic [ROB_W_DEF-1:0]  qk;
    logic [DATA_W_DEF-1:0] vj;
    logic [DATA_W_DEF-1:0] vk;
    logic [DATA_W_DEF-1:0] imm;
    logic [DATA_W_DEF-1:0] pc;
    logic [ROB_W_DEF-1:0]  rob;
    logic                  busy;
  } rs_entry_t;

  // Index width for an N-entry vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_prio_pick.sv
// Find-first-set over a request vector: lowest set index plus a found flag.
module rs_prio_pick
  import rs_station_param_pkg::*;
#(
  parameter int N     = RS_DEPTH_DEF,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station_param.sv
// Parametrised reservation station: multi-CDB snoop with allocation bypass, one issue per cycle.
// Build option RS_AGE_ORDER_EN selects oldest-ready issue via an age matrix; default is lowest index.
module rs_station_param
  import rs_station_param_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_W     = ROB_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int CDB_PORTS = CDB_PORTS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          flush,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  input  logic [OP_W-1:0]               alloc_op,
  input  logic [DATA_W-1:0]             alloc_imm,
  input  logic [DATA_W-1:0]             alloc_pc,
  input  logic [ROB_W-1:0]              alloc_qj,
  input  logic [ROB_W-1:0]              alloc_qk,
  input  logic [DATA_W-1:0]             alloc_vj,
  input  logic [DATA_W-1:0]             alloc_vk,
  input  logic [ROB_W-1:0]              alloc_rob,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_W-1:0]    cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [OP_W-1:0]               issue_op,
  output logic [DATA_W-1:0]             issue_vj,
  output logic [DATA_W-1:0]             issue_vk,
  output logic [DATA_W-1:0]             issue_imm,
  output logic [DATA_W-1:0]             issue_pc,
  output logic [ROB_W-1:0]              issue_rob
);

  localparam int IDX_W = idx_w(RS_DEPTH);
  localparam logic [ROB_W-1:0] TAG_NONE = ROB_W'(ZERO_ROB);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  qj;
    logic [ROB_W-1:0]  qk;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [ROB_W-1:0]  rob;
    logic              busy;
  } entry_t;

  entry_t [RS_DEPTH-1:0] ent;

  logic [RS_DEPTH-1:0]             busy_vec;
  logic [RS_DEPTH-1:0]             free_vec;
  logic [RS_DEPTH-1:0]             ready_vec;
  logic [RS_DEPTH-1:0]             pick_req;
  logic [RS_DEPTH-1:0]             snp_j_hit;
  logic [RS_DEPTH-1:0]             snp_k_hit;
  logic [RS_DEPTH-1:0][DATA_W-1:0] snp_j_data;
  logic [RS_DEPTH-1:0][DATA_W-1:0] snp_k_data;
  logic [IDX_W-1:0]                alloc_idx;
  logic [IDX_W-1:0]                sel_idx;
  logic                            free_found;
  logic                            sel_found;
  logic                            load;
  logic                            do_alloc;
  logic                            issue_fire;
  logic                            byp_j_hit;
  logic                            byp_k_hit;
  logic [DATA_W-1:0]               byp_j_data;
  logic [DATA_W-1:0]               byp_k_data;
  entry_t                          new_ent;

  // Returns {hit, data}; scanning high to low lets the lowest bus index win.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = CDB_PORTS - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (tag != TAG_NONE) && (cdb_tag[k*ROB_W +: ROB_W] == tag))
        r = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    busy_vec   = '0;
    ready_vec  = '0;
    snp_j_hit  = '0;
    snp_k_hit  = '0;
    snp_j_data = '0;
    snp_k_data = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && (ent[i].qj == TAG_NONE) && (ent[i].qk == TAG_NONE);
      {snp_j_hit[i], snp_j_data[i]} = cdb_lookup(ent[i].qj);
      {snp_k_hit[i], snp_k_data[i]} = cdb_lookup(ent[i].qk);
    end
  end

  assign free_vec = ~busy_vec;

  rs_prio_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_free_pick (
    .req   (free_vec),
    .idx   (alloc_idx),
    .found (free_found)
  );

  assign alloc_ready = free_found;
  assign do_alloc    = alloc_valid && alloc_ready && !flush;
  assign load        = !issue_valid || issue_ready;
  assign issue_fire  = load && sel_found;

  always_comb begin
    {byp_j_hit, byp_j_data} = cdb_lookup(alloc_qj);
    {byp_k_hit, byp_k_data} = cdb_lookup(alloc_qk);
    new_ent      = '0;
    new_ent.op   = alloc_op;
    new_ent.qj   = byp_j_hit ? TAG_NONE : alloc_qj;
    new_ent.qk   = byp_k_hit ? TAG_NONE : alloc_qk;
    new_ent.vj   = byp_j_hit ? byp_j_data : alloc_vj;
    new_ent.vk   = byp_k_hit ? byp_k_data : alloc_vk;
    new_ent.imm  = alloc_imm;
    new_ent.pc   = alloc_pc;
    new_ent.rob  = alloc_rob;
    new_ent.busy = 1'b1;
  end

`ifdef RS_AGE_ORDER_EN
  // age[i][j] set means entry j is older than entry i.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age;
  logic [RS_DEPTH-1:0]               grant;
  logic [RS_DEPTH-1:0]               clr_mask;

  always_comb begin
    grant = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      grant[i] = ready_vec[i] && !(|(age[i] & ready_vec));
  end

  assign pick_req = grant;
  assign clr_mask = issue_fire ? ({{(RS_DEPTH-1){1'b0}}, 1'b1} << sel_idx) : '0;

  // New column is cleared so older rows forget a stale occupant of the reused slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
    end else if (ena) begin
      if (flush) begin
        age <= '0;
      end else if (do_alloc) begin
        for (int r = 0; r < RS_DEPTH; r++)
          age[r][alloc_idx] <= 1'b0;
        age[alloc_idx] <= busy_vec & ~clr_mask;
      end
    end
  end
`else
  assign pick_req = ready_vec;
`endif

  rs_prio_pick #(.N(RS_DEPTH), .IDX_W(IDX_W)) u_sel_pick (
    .req   (pick_req),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ent         <= '0;
      issue_valid <= 1'b0;
      issue_op    <= OP_W'(NOP_OP);
      issue_vj    <= '0;
      issue_vk    <= '0;
      issue_imm   <= '0;
      issue_pc    <= '0;
      issue_rob   <= '0;
    end else if (ena) begin
      if (flush) begin
        for (int i = 0; i < RS_DEPTH; i++)
          ent[i].busy <= 1'b0;
        issue_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (ent[i].busy && snp_j_hit[i]) begin
            ent[i].qj <= TAG_NONE;
            ent[i].vj <= snp_j_data[i];
          end
          if (ent[i].busy && snp_k_hit[i]) begin
            ent[i].qk <= TAG_NONE;
            ent[i].vk <= snp_k_data[i];
          end
        end
        if (issue_fire) begin
          issue_valid       <= 1'b1;
          issue_op          <= ent[sel_idx].op;
          issue_vj          <= ent[sel_idx].vj;
          issue_vk          <= ent[sel_idx].vk;
          issue_imm         <= ent[sel_idx].imm;
          issue_pc          <= ent[sel_idx].pc;
          issue_rob         <= ent[sel_idx].rob;
          ent[sel_idx].busy <= 1'b0;
        end else if (load) begin
          issue_valid <= 1'b0;
        end
        // Alloc slot was free pre-edge, so it never collides with the issuing entry.
        if (do_alloc)
          ent[alloc_idx] <= new_ent;
      end
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Directed self-checking bench for rs_station_param: vector table plus multi-cycle sequences.
module tb_rs_station_param;

  logic        clk = 1'b0;
  logic        rst, ena, flush;
  logic        alloc_valid, alloc_ready;
  logic [5:0]  alloc_op;
  logic [31:0] alloc_imm, alloc_pc, alloc_vj, alloc_vk;
  logic [3:0]  alloc_qj, alloc_qk, alloc_rob;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
  logic [3:0]  issue_rob;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rs_station_param dut (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_imm(alloc_imm), .alloc_pc(alloc_pc), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk), .alloc_rob(alloc_rob),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_imm(issue_imm),
    .issue_pc(issue_pc), .issue_rob(issue_rob)
  );

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
    logic [3:0]  rob;
    logic [1:0]  cv;
    logic [3:0]  t0, t1;
    logic [31:0] d0, d1;
    logic [31:0] evj, evk;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    flush       = 1'b0;
  endtask

  task automatic put_alloc(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                           input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] rob);
    alloc_valid = 1'b1;
    alloc_op    = op;
    alloc_qj    = qj;
    alloc_qk    = qk;
    alloc_vj    = vj;
    alloc_vk    = vk;
    alloc_rob   = rob;
    alloc_imm   = 32'h100 + 32'(rob);
    alloc_pc    = 32'h1000 + 32'(rob);
  endtask

  task automatic bcast(input logic [1:0] cv, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [31:0] d0, input logic [31:0] d1);
    cdb_valid = cv;
    cdb_tag   = {t1, t0};
    cdb_data  = {d1, d0};
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_issue(input string nm, input logic [3:0] rob, input logic [31:0] vj);
    chk({nm, "_valid"}, 32'(issue_valid), 32'd1);
    chk({nm, "_rob"}, 32'(issue_rob), 32'(rob));
    chk({nm, "_vj"}, issue_vj, vj);
  endtask

  initial begin
    vecs[0] = '{6'd1, 4'd0,  4'd0, 32'h5,  32'h7,    4'd3, 2'b00, 4'd0, 4'd0,  32'h0,   32'h0,    32'h5,    32'h7};
    vecs[1] = '{6'd2, 4'd0,  4'd6, 32'h40, 32'hdead, 4'd4, 2'b01, 4'd6, 4'd0,  32'h11,  32'h0,    32'h40,   32'h11};
    vecs[2] = '{6'd3, 4'd9,  4'd0, 32'h50, 32'h60,   4'd5, 2'b10, 4'd0, 4'd9,  32'h0,   32'h22,   32'h22,   32'h60};
    vecs[3] = '{6'd4, 4'd5,  4'd5, 32'h1,  32'h2,    4'd6, 2'b11, 4'd5, 4'd5,  32'ha,   32'hb,    32'ha,    32'ha};
    vecs[4] = '{6'd5, 4'd0,  4'd0, 32'h33, 32'h44,   4'd7, 2'b01, 4'd0, 4'd0,  32'h77,  32'h0,    32'h33,   32'h44};
    vecs[5] = '{6'd6, 4'd12, 4'd3, 32'h0,  32'h0,    4'd8, 2'b11, 4'd3, 4'd12, 32'h300, 32'h1200, 32'h1200, 32'h300};

    rst = 1'b1; ena = 1'b1; issue_ready = 1'b1;
    idle();
    put_alloc(6'd0, 4'd0, 4'd0, 32'h0, 32'h0, 4'd0);
    alloc_valid = 1'b0;
    bcast(2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    step(); step();
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_issue_op", 32'(issue_op), 32'd0);
    chk("rst_issue_vj", issue_vj, 32'd0);
    chk("rst_issue_rob", 32'(issue_rob), 32'd0);
    rst = 1'b0;
    step();

    // Single-op vectors: plain, bypass on each bus, bus priority, tag-0 no-match, dual bypass.
    for (int v = 0; v < 6; v++) begin
      put_alloc(vecs[v].op, vecs[v].qj, vecs[v].qk, vecs[v].vj, vecs[v].vk, vecs[v].rob);
      bcast(vecs[v].cv, vecs[v].t0, vecs[v].t1, vecs[v].d0, vecs[v].d1);
      step(); idle();
      chk($sformatf("vec%0d_early", v), 32'(issue_valid), 32'd0);
      step();
      chk($sformatf("vec%0d_valid", v), 32'(issue_valid), 32'd1);
      chk($sformatf("vec%0d_op", v), 32'(issue_op), 32'(vecs[v].op));
      chk($sformatf("vec%0d_vj", v), issue_vj, vecs[v].evj);
      chk($sformatf("vec%0d_vk", v), issue_vk, vecs[v].evk);
      chk($sformatf("vec%0d_rob", v), 32'(issue_rob), 32'(vecs[v].rob));
      chk($sformatf("vec%0d_imm", v), issue_imm, 32'h100 + 32'(vecs[v].rob));
      chk($sformatf("vec%0d_pc", v), issue_pc, 32'h1000 + 32'(vecs[v].rob));
      step();
      chk($sformatf("vec%0d_drain", v), 32'(issue_valid), 32'd0);
    end

    // Wait on tag 4, broadcast later on bus 1.
    put_alloc(6'd7, 4'd4, 4'd0, 32'h0, 32'h5, 4'd9);
    step(); idle();
    step();
    chk("wait_no_issue", 32'(issue_valid), 32'd0);
    bcast(2'b10, 4'd0, 4'd4, 32'h0, 32'h99);
    step(); idle();
    chk("wait_bcast_edge", 32'(issue_valid), 32'd0);
    step();
    chk_issue("wait_issue", 4'd9, 32'h99);
    step();
    chk("wait_drain", 32'(issue_valid), 32'd0);

    // Fill all 16 entries on tag 2, drop a 17th, then drain in slot order.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fill_ready%0d", i), 32'(alloc_ready), 32'd1);
      put_alloc(6'd8, 4'd2, 4'd0, 32'h0, 32'(i), 4'(i));
      step();
    end
    idle();
    chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
    put_alloc(6'd9, 4'd0, 4'd0, 32'hbad, 32'hbad, 4'd15);
    step(); idle();
    chk("full_drop_ready", 32'(alloc_ready), 32'd0);
    chk("full_drop_issue", 32'(issue_valid), 32'd0);
    bcast(2'b01, 4'd2, 4'd0, 32'h2222, 32'h0);
    step(); idle();
    chk("full_bcast_edge", 32'(issue_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk_issue($sformatf("full_iss%0d", i), 4'(i), 32'h2222);
      chk($sformatf("full_vk%0d", i), issue_vk, 32'(i));
    end
    step();
    chk("full_end_valid", 32'(issue_valid), 32'd0);
    chk("full_end_ready", 32'(alloc_ready), 32'd1);

    // Stall: payload held for 5 cycles, waiting entries kept.
    issue_ready = 1'b0;
    put_alloc(6'd10, 4'd0, 4'd0, 32'h10, 32'h0, 4'd1); step();
    put_alloc(6'd10, 4'd0, 4'd0, 32'h20, 32'h0, 4'd2); step();
    put_alloc(6'd10, 4'd0, 4'd0, 32'h30, 32'h0, 4'd3); step();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk_issue($sformatf("stall%0d", i), 4'd1, 32'h10);
      step();
    end
    issue_ready = 1'b1;
    step();
`ifdef RS_AGE_ORDER_EN
    chk_issue("stall_rel0", 4'd2, 32'h20);
    step();
    chk_issue("stall_rel1", 4'd3, 32'h30);
`else
    chk_issue("stall_rel0", 4'd3, 32'h30);
    step();
    chk_issue("stall_rel1", 4'd2, 32'h20);
`endif
    step();
    chk("stall_drain", 32'(issue_valid), 32'd0);

    // Enable low freezes allocation and the issue register.
    ena = 1'b0;
    put_alloc(6'd11, 4'd0, 4'd0, 32'h10a, 32'h0, 4'd10);
    step(); step(); idle();
    ena = 1'b1;
    step();
    chk("ena_no_alloc", 32'(issue_valid), 32'd0);
    put_alloc(6'd11, 4'd0, 4'd0, 32'h10b, 32'h0, 4'd11);
    step(); idle();
    step();
    chk_issue("ena_issue", 4'd11, 32'h10b);
    ena = 1'b0;
    step(); step();
    chk_issue("ena_frozen", 4'd11, 32'h10b);
    ena = 1'b1;
    step();
    chk("ena_resume", 32'(issue_valid), 32'd0);

    // Flush with 8 waiting entries and a stalled issue.
    issue_ready = 1'b0;
    put_alloc(6'd12, 4'd0, 4'd0, 32'h12, 32'h0, 4'd12);
    step();
    for (int i = 0; i < 8; i++) begin
      put_alloc(6'd13, 4'd2, 4'd0, 32'h0, 32'h0, 4'(i));
      step();
    end
    idle();
    chk_issue("pre_flush", 4'd12, 32'h12);
    flush = 1'b1;
    put_alloc(6'd14, 4'd0, 4'd0, 32'h13, 32'h0, 4'd13);
    step(); idle();
    chk("flush_valid", 32'(issue_valid), 32'd0);
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    issue_ready = 1'b1;
    bcast(2'b01, 4'd2, 4'd0, 32'h55, 32'h0);
    step(); idle();
    step(); step();
    chk("flush_empty", 32'(issue_valid), 32'd0);

    // Slot reuse: Z,A,B in slots 0..2, Z issues, C takes slot 0.
    put_alloc(6'd15, 4'd7, 4'd0, 32'h0, 32'h0, 4'd1); step();
    put_alloc(6'd15, 4'd5, 4'd0, 32'h0, 32'h0, 4'd2); step();
    put_alloc(6'd15, 4'd5, 4'd0, 32'h0, 32'h0, 4'd3); step();
    idle();
    bcast(2'b01, 4'd7, 4'd0, 32'h70, 32'h0);
    step(); idle();
    step();
    chk_issue("age_z", 4'd1, 32'h70);
    put_alloc(6'd15, 4'd5, 4'd0, 32'h0, 32'h0, 4'd4);
    step(); idle();
    chk("age_gap", 32'(issue_valid), 32'd0);
    bcast(2'b10, 4'd0, 4'd5, 32'h0, 32'h50);
    step(); idle();
    step();
`ifdef RS_AGE_ORDER_EN
    chk_issue("age_first", 4'd2, 32'h50);
    step();
    chk_issue("age_second", 4'd3, 32'h50);
    step();
    chk_issue("age_third", 4'd4, 32'h50);
`else
    chk_issue("age_first", 4'd4, 32'h50);
    step();
    chk_issue("age_second", 4'd2, 32'h50);
    step();
    chk_issue("age_third", 4'd3, 32'h50);
`endif
    step();
    chk("age_drain", 32'(issue_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_station_param.md
Name: rs_station_param

Overview:
- Parametrised successor to the single-CDB, fixed-size reservation station.
- Holds up to RS_DEPTH renamed ALU ops and snoops CDB_PORTS result buses, including a same-cycle bypass at allocation.
- Issues one ready op per cycle to the ALU through a valid/ready handshake; supports full flush on branch mispredict.
- Sits between decoder/dispatch and the ALU.

Parameters:
RS_DEPTH, 16, number of entries (2..64)
DATA_W, 32, operand/imm/pc width
ROB_W, 4, ROB tag width; tag 0 means "no dependency"
OP_W, 6, operation encoding width
CDB_PORTS, 2, number of broadcast buses (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  global enable; low freezes all state
flush  in  1  mispredict flush
alloc_valid  in  1  dispatch request
alloc_ready  out  1  at least one free entry (combinational from busy)
alloc_op  in  OP_W  operation
alloc_imm, alloc_pc  in  DATA_W each  immediate, PC
alloc_qj, alloc_qk  in  ROB_W each  producer tags (0 = value valid)
alloc_vj, alloc_vk  in  DATA_W each  operand values
alloc_rob  in  ROB_W  destination ROB tag
cdb_valid  in  CDB_PORTS  per-bus valid
cdb_tag  in  CDB_PORTS*ROB_W  flattened tags, bus k at [k*ROB_W +: ROB_W]
cdb_data  in  CDB_PORTS*DATA_W  flattened data
issue_valid  out  1  registered op presented to ALU
issue_ready  in  1  ALU accepts
issue_op, issue_vj, issue_vk, issue_imm, issue_pc, issue_rob  out  matching widths  registered payload

Behaviour:
- Reset (priority over everything): all busy=0; issue_valid=0; all issue_* payloads=0; alloc_ready=1 after reset.
- ena=0: no state changes; CDB traffic is ignored (upstream guarantees none while ena is low).
- Flush (ena=1, rst=0): clears all busy bits and issue_valid next cycle. Alloc and issue are suppressed that cycle.
- Allocation fires when alloc_valid & alloc_ready.
  - The entry is the lowest-index free slot, judged on the pre-edge busy vector; a slot freed this cycle is not reused until next cycle.
  - If alloc_qj (or alloc_qk) is nonzero and equals any valid cdb_tag this cycle, the entry captures that cdb_data with Q=0 (bypass).
- Alloc while full (alloc_ready=0): alloc_valid is ignored; no entry is written.
- Snoop: each busy entry with Qx≠0 matching a valid bus sets Qx←0 and Vx←data.
  - Multiple buses with the same tag: the lowest bus index wins. The ROB guarantees unique tags, so this is defensive only.
  - Tag 0 never matches.
- Ready: busy & Qj==0 & Qk==0, evaluated on registered state, so a value captured this edge is issuable next cycle.
- Issue register load condition: !issue_valid | issue_ready (output empty or draining).
  - When the condition holds and some entry is ready: select per the selection policy, load the payload, set issue_valid=1, and clear that entry's busy.
  - When the condition holds and nothing is ready: issue_valid←0.
  - Stall (issue_valid & !issue_ready): payload held stable, no selection, no busy cleared.
- Latency: alloc with both operands ready → issue_valid 1 cycle later (earliest).
- Throughput: 1 issue/cycle with issue_ready held high.
- Selection policy (default): lowest ready index.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined: oldest-first selection.
  - Keep an RS_DEPTH×RS_DEPTH age matrix. On alloc, the new row is set to "younger than all busy entries".
  - Select the ready entry with no older ready entry.
  - Flush/reset clears the matrix.
- Undefined: lowest-index priority; no matrix logic.

Decomposition:
- Shared package/constants file holds the following, defaulted by the parameters:
  - ZERO_ROB tag
  - NOP op encoding
  - the entry record typedef (op, qj, qk, vj, vk, imm, pc, rob, busy)
- One natural sub-module, rs_prio_pick: parametrised find-first-set over RS_DEPTH returning index and found flag. Used for both free-slot and ready selection.
- The age-matrix select lives inline under the macro.

Test Plan:
- Reset then alloc op=ADD, qj=qk=0, vj=5, vk=7, rob=3 → next cycle issue_valid=1, issue_vj=5, issue_vk=7, issue_rob=3.
- Alloc qj=4 with no broadcast; then cdb_valid[1]=1, tag=4, data=0x99 → entry issues one cycle after the broadcast edge with issue_vj=0x99.
- Bypass: alloc qk=6 in the same cycle as cdb_valid[0]=1, tag=6, data=0x11 → issues next cycle with issue_vk=0x11.
- Fill all 16 entries each waiting on tag 2 → alloc_ready=0 and a 17th alloc_valid is dropped. Broadcast tag 2 → 16 consecutive issues with issue_ready=1, then alloc_ready=1.
- Hold issue_ready=0 for 5 cycles with issue_valid=1 → payload unchanged each cycle, no busy cleared; issue_ready=1 → next ready entry appears the following cycle.
- Flush with 8 busy and issue_valid=1 → next cycle issue_valid=0 and alloc_ready=1. With RS_AGE_ORDER_EN: alloc slots in order A,B, free slot 0 and realloc C, make all ready → issue order A/B by age, then C.
